// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the framed serial transmitter: FSM encoding and line levels.
package serial_word_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Parity bit for a captured word; odd_sel=1 makes the total count of ones odd.
    function automatic logic calc_parity(input logic [63:0] word, input logic odd_sel);
        return (^word) ^ odd_sel;
    endfunction

endpackage

// File: rtl/serial_word_tx_piso.sv
// Parallel-in serial-out shift register; bit 0 is the next bit to go on the line.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit0
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign bit0 = shreg_q[0];

endmodule

// File: rtl/serial_word_tx.sv
// Framed transmitter: start bit, WIDTH data bits LSB first, optional parity, stop bit.
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          par_q, par_d;
    logic          sout_q, sout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;
    logic          shift_en;
    logic          data_bit;
    logic [63:0]   din_ext;

    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_STOP);
    assign accept     = load_valid && load_ready;
    assign din_ext    = 64'(din);

    // Data bits go out straight from the shifter, so shifting happens on every
    // edge that enters or stays in DATA; bit 0 is sampled before the shift.
    assign shift_en = (state_d == ST_DATA);

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .res   (res),
        .load  (accept),
        .shift (shift_en),
        .din   (din),
        .bit0  (data_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_START;
            ST_START:  state_d = ST_DATA;
            ST_DATA:   if (cnt_q == LAST_IDX) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = accept ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, decoded from the state being entered so they line
    // up with the state on the same edge.
    always_comb begin
        sout_d = LINE_IDLE;
        busy_d = 1'b1;
        done_d = 1'b0;
        unique case (state_d)
            ST_IDLE:   busy_d = 1'b0;
            ST_START:  sout_d = START_BIT;
            ST_DATA:   sout_d = data_bit;
            ST_PARITY: sout_d = par_q;
            ST_STOP: begin
                sout_d = STOP_BIT;
                done_d = 1'b1;
            end
            default: begin
                sout_d = LINE_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // Bit counter and parity captured alongside the word
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_START) begin
            cnt_d = '0;
        end else if ((state_q == ST_DATA) && (cnt_q != LAST_IDX)) begin
            cnt_d = cnt_q + CW'(1);
        end
        par_d = accept ? calc_parity(din_ext, 1'(PARITY_ODD)) : par_q;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q  <= '0;
            par_q  <= 1'b0;
            sout_q <= LINE_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            par_q  <= par_d;
            sout_q <= sout_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
